// File: rtl/transaction_sequencer.sv
// transaction_sequencer: step sequencer with per-step watchdog retry/fail and an idle (stale) timer
module transaction_sequencer #(
    parameter int NUM_STEPS      = 4,
    parameter int STEP_W         = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 2,
    parameter int IDLE_CYCLES    = 500000000,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
    localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1,
    localparam int IW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_STEPS-1:0] done_step,
    output logic [STEP_W-1:0]    step,
    output logic                 busy,
    output logic                 finished,
    output logic                 failed,
    output logic                 retry_pulse,
    output logic [RW-1:0]        retry_count,
    output logic                 idle_expired
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
    state_t state, state_n;
    logic [STEP_W-1:0] step_n;
    logic [WW-1:0] wd, wd_n;
    logic [RW-1:0] rc_n;
    logic [IW-1:0] idle_cnt, idle_n, idle_sat;
    logic finished_n, retry_n, failed_n, done_hit;
    assign done_hit = |(done_step & (NUM_STEPS'(1) << (step - STEP_W'(1))));
    assign idle_sat = (idle_cnt == IW'(IDLE_CYCLES - 1)) ? idle_cnt : idle_cnt + IW'(1);
    always_comb begin
        state_n    = state;
        step_n     = step;
        wd_n       = wd;
        rc_n       = retry_count;
        idle_n     = idle_cnt;
        finished_n = 1'b0;
        retry_n    = 1'b0;
        failed_n   = failed;
        if (abort) begin
            state_n  = IDLE;
            step_n   = '0;
            wd_n     = '0;
            rc_n     = '0;
            idle_n   = '0;
            failed_n = 1'b0;
        end else begin
            unique case (state)
                IDLE, FAIL: begin
                    idle_n = idle_sat;
                    if (start) begin
                        state_n  = RUN;
                        step_n   = STEP_W'(1);
                        wd_n     = '0;
                        rc_n     = '0;
                        idle_n   = '0;
                        failed_n = 1'b0;
                    end
                end
                RUN: begin
                    if (done_hit) begin
                        wd_n = '0;
                        rc_n = '0;
                        if (step == STEP_W'(NUM_STEPS)) begin
                            state_n    = DONE;
                            step_n     = '0;
                            finished_n = 1'b1;
                        end else begin
                            step_n = step + STEP_W'(1);
                        end
                    end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        wd_n = '0;
                        if (retry_count < RW'(MAX_RETRIES)) begin
                            rc_n    = retry_count + RW'(1);
                            retry_n = 1'b1;
                        end else begin
                            state_n  = FAIL;
                            step_n   = '0;
                            failed_n = 1'b1;
                        end
                    end else begin
                        wd_n = wd + WW'(1);
                    end
                end
                DONE: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            step         <= '0;
            wd           <= '0;
            retry_count  <= '0;
            idle_cnt     <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            failed       <= 1'b0;
            retry_pulse  <= 1'b0;
            idle_expired <= 1'b0;
        end else begin
            state        <= state_n;
            step         <= step_n;
            wd           <= wd_n;
            retry_count  <= rc_n;
            idle_cnt     <= idle_n;
            busy         <= state_n == RUN;
            finished     <= finished_n;
            failed       <= failed_n;
            retry_pulse  <= retry_n;
            idle_expired <= idle_n == IW'(IDLE_CYCLES - 1);
        end
    end
endmodule

// File: tb/tb_transaction_sequencer.sv
// tb_transaction_sequencer: scoreboard bench; a mode/age reference model predicts every cycle's outputs
module tb_transaction_sequencer;
    localparam int N = 4, TO = 8, MR = 2, IC = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] done_step = 4'd0;
    logic [2:0] step;
    logic [1:0] retry_count;
    logic busy, finished, failed, retry_pulse, idle_expired;
    typedef struct packed {
        logic [2:0] step;
        logic busy;
        logic finished;
        logic failed;
        logic retry_pulse;
        logic [1:0] rc;
        logic idle_expired;
    } obs_t;
    obs_t q[$];
    int checks = 0, passes = 0;
    int mode, cur, age, tries, idle_age;
    bit jf, jr;

    transaction_sequencer #(.NUM_STEPS(N), .STEP_W(3), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR),
                            .IDLE_CYCLES(IC)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .done_step(done_step),
        .step(step), .busy(busy), .finished(finished), .failed(failed),
        .retry_pulse(retry_pulse), .retry_count(retry_count), .idle_expired(idle_expired)
    );

    always #5 clock = ~clock;

    function automatic obs_t observed();
        return {step, busy, finished, failed, retry_pulse, retry_count, idle_expired};
    endfunction

    function automatic obs_t predict();
        return '{step: (mode == M_RUN) ? 3'(cur) : 3'd0, busy: mode == M_RUN, finished: jf,
                 failed: mode == M_FAIL, retry_pulse: jr, rc: 2'(tries), idle_expired: idle_age >= IC - 1};
    endfunction

    task automatic model_reset();
        mode = M_IDLE; cur = 0; age = 0; tries = 0; idle_age = 0; jf = 0; jr = 0;
    endtask

    task automatic begin_run();
        mode = M_RUN; cur = 1; age = 0; tries = 0; idle_age = 0;
    endtask

    task automatic model_step(bit s, bit a, logic [3:0] d);
        jf = 0;
        jr = 0;
        if (a) begin
            model_reset();
        end else if (mode == M_IDLE || mode == M_FAIL) begin
            if (s) begin_run();
            else if (idle_age < IC - 1) idle_age++;
        end else if (mode == M_DONE) begin
            mode = M_IDLE;
        end else if (d[cur-1]) begin
            age = 0;
            tries = 0;
            if (cur == N) begin
                mode = M_DONE;
                jf = 1;
            end else cur++;
        end else if (age == TO - 1) begin
            age = 0;
            if (tries < MR) begin
                tries++;
                jr = 1;
            end else mode = M_FAIL;
        end else age++;
    endtask

    // Called right after a falling edge; returns right after the next one.
    task automatic cyc(bit s, bit a, logic [3:0] d);
        start = s;
        abort = a;
        done_step = d;
        @(posedge clock);
        model_step(s, a, d);
        q.push_back(predict());
        @(negedge clock);
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0);
    endtask

    task automatic check_zero(string tag);
        obs_t g;
        g = observed();
        checks++;
        if (g === '0) passes++;
        else $display("FAIL %s: outputs=%b required all zero", tag, g);
    endtask

    task automatic hw_reset();
        #1;
        start = 0; abort = 0; done_step = 0;
        reset = 1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset = 0;
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                g = observed();
                checks++;
                if (g === e) passes++;
                else $display("FAIL outputs t=%0t: got step=%0d busy=%b fin=%b failed=%b rp=%b rc=%0d idle=%b, required step=%0d busy=%b fin=%b failed=%b rp=%b rc=%0d idle=%b",
                              $time, g.step, g.busy, g.finished, g.failed, g.retry_pulse, g.rc, g.idle_expired,
                              e.step, e.busy, e.finished, e.failed, e.retry_pulse, e.rc, e.idle_expired);
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(negedge clock);
        check_zero("reset_state");
        reset = 0;
        model_reset();
        // idle timer expiry from reset, then start clears it
        idle_cycles(20);
        cyc(1, 0, 4'd0);
        idle_cycles(1);
        // happy path
        for (int k = 0; k < N; k++) begin
            idle_cycles(2);
            cyc(0, 0, 4'(1 << k));
        end
        idle_cycles(3);
        // two retries then progress; finish the remaining steps
        cyc(1, 0, 4'd0);
        idle_cycles(20);
        for (int k = 0; k < N; k++) cyc(0, 0, 4'(1 << k));
        idle_cycles(2);
        // exhaust retries, restart from FAIL, then abort
        cyc(1, 0, 4'd0);
        idle_cycles(28);
        cyc(1, 0, 4'd0);
        idle_cycles(3);
        cyc(0, 1, 4'd0);
        // wrong done bits ignored; done on the timeout cycle wins
        cyc(1, 0, 4'd0);
        cyc(0, 0, 4'b0001);
        repeat (3) cyc(0, 0, 4'b0101);
        idle_cycles(4);
        cyc(0, 0, 4'b0010);
        idle_cycles(2);
        cyc(0, 1, 4'd0);
        // abort beats done and start
        cyc(1, 0, 4'd0);
        cyc(1, 1, 4'b0001);
        idle_cycles(2);
        // async reset mid step 3
        cyc(1, 0, 4'd0);
        cyc(0, 0, 4'b0001);
        cyc(0, 0, 4'b0010);
        idle_cycles(2);
        hw_reset();
        idle_cycles(18);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s, a;
            int r;
            logic [3:0] d;
            s = $urandom_range(0, ((i / 500) % 2) ? 40 : 3) == 0;
            a = $urandom_range(0, 39) == 0;
            r = $urandom_range(0, 11);
            d = (r == 0) ? 4'($urandom_range(0, 15)) : ((r < 3 && cur > 0) ? 4'(1 << (cur - 1)) : 4'd0);
            cyc(s, a, d);
            if ($urandom_range(0, 599) == 0) hw_reset();
        end
        #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
